// File: rtl/imm_decode_if.sv
// Handshake bundle for imm_decode_stage: upstream instruction channel and downstream decoded-immediate channel.
interface imm_decode_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [2:0]        out_fmt;
   logic              out_illegal;
   logic              out_rvc;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_rvc, out_tag
   );

   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_rvc, out_tag
   );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage with a two-entry (output + skid) buffer and registered in_ready.
// Define IMM_DECODE_RVC_EN to add decode of a subset of RV32C compressed encodings.
module imm_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   imm_decode_if.slave bus
);
   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_S    = 3'd1;
   localparam logic [2:0] FMT_B    = 3'd2;
   localparam logic [2:0] FMT_U    = 3'd3;
   localparam logic [2:0] FMT_J    = 3'd4;
   localparam logic [2:0] FMT_NONE = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
`ifdef IMM_DECODE_RVC_EN
      logic             rvc;
`endif
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   entry_t             dec;
   entry_t             out_q;
   entry_t             skid_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               in_ready_nxt;
   logic               out_valid_nxt;
   logic               load_out;
   logic               load_skid;
   logic               out_from_skid;
   logic               in_xfer;
   logic               out_xfer;
   logic [31:0]        ins;
   logic signed [31:0] imm32;

   assign ins      = bus.in_instr;
   assign in_xfer  = bus.in_valid & in_ready_q;
   assign out_xfer = out_valid_q & bus.out_ready;

   // Format classification and 32-bit sign-extended immediate, widened to XLEN at the end
   always_comb begin
      dec         = '0;
      imm32       = '0;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b0;
      dec.tag     = bus.in_tag;
      case (ins[6:0])
         7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: begin
            dec.fmt = FMT_I;
            imm32   = 32'($signed(ins[31:20]));
         end
         7'b0100011: begin
            dec.fmt = FMT_S;
            imm32   = 32'($signed({ins[31:25], ins[11:7]}));
         end
         7'b1100011: begin
            dec.fmt = FMT_B;
            imm32   = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         end
         7'b0010111, 7'b0110111: begin
            dec.fmt = FMT_U;
            imm32   = $signed({ins[31:12], 12'h000});
         end
         7'b1101111: begin
            dec.fmt = FMT_J;
            imm32   = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         7'b0110011: dec.fmt = FMT_NONE;
         default:    dec.illegal = 1'b1;
      endcase
`ifdef IMM_DECODE_RVC_EN
      // Any 16-bit encoding is flagged rvc; unsupported ones fall through as illegal
      if (ins[1:0] != 2'b11) begin
         imm32       = '0;
         dec.fmt     = FMT_NONE;
         dec.illegal = 1'b1;
         dec.rvc     = 1'b1;
         case ({ins[1:0], ins[15:13]})
            5'b00_010: begin
               dec.fmt     = FMT_I;
               dec.illegal = 1'b0;
               imm32       = $signed(32'({ins[5], ins[12:10], ins[6], 2'b00}));
            end
            5'b00_110: begin
               dec.fmt     = FMT_S;
               dec.illegal = 1'b0;
               imm32       = $signed(32'({ins[5], ins[12:10], ins[6], 2'b00}));
            end
            5'b01_000, 5'b01_010: begin
               dec.fmt     = FMT_I;
               dec.illegal = 1'b0;
               imm32       = 32'($signed({ins[12], ins[6:2]}));
            end
            5'b01_011: begin
               if (ins[11:7] != 5'd0 && ins[11:7] != 5'd2) begin
                  dec.fmt     = FMT_U;
                  dec.illegal = 1'b0;
                  imm32       = 32'($signed({ins[12], ins[6:2], 12'h000}));
               end
            end
            5'b01_101: begin
               dec.fmt     = FMT_J;
               dec.illegal = 1'b0;
               imm32       = 32'($signed({ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                          ins[2], ins[11], ins[5:3], 1'b0}));
            end
            5'b01_110, 5'b01_111: begin
               dec.fmt     = FMT_B;
               dec.illegal = 1'b0;
               imm32       = 32'($signed({ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0}));
            end
            default: ;
         endcase
      end
`endif
      dec.imm = XLEN'(imm32);
   end

   // Occupancy FSM: next state, register load controls, and next values of the registered handshakes
   always_comb begin
      state_nxt     = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               load_out  = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
               load_out  = 1'b1;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_nxt     = ONE;
               load_out      = 1'b1;
               out_from_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      in_ready_nxt  = (state_nxt != FULL);
      out_valid_nxt = (state_nxt != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_q.fmt   <= FMT_NONE;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= in_ready_nxt;
         out_valid_q <= out_valid_nxt;
         if (load_out) begin
            out_q <= out_from_skid ? skid_q : dec;
         end
      end
   end

   // Skid contents are only meaningful in FULL, so they need no reset
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_q <= dec;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_fmt     = out_q.fmt;
   assign bus.out_illegal = out_q.illegal;
   assign bus.out_tag     = out_q.tag;
`ifdef IMM_DECODE_RVC_EN
   assign bus.out_rvc     = out_q.rvc;
`else
   assign bus.out_rvc     = 1'b0;
`endif

endmodule
